// File: rtl/psum_drain_if.sv
// Drain-side bundle: skewed column partial sums in, realigned rows out.
// The drain is the slave; whoever feeds psums and accepts rows is the master.
interface psum_drain_if #(
    parameter int COLS  = 4,
    parameter int ACC_W = 16
);
    logic [COLS*ACC_W-1:0] psum_in;
    logic [COLS-1:0]       psum_valid;
    logic [COLS*ACC_W-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;
    logic                  ovf;
    logic                  ovf_clr;

    modport master (
        output psum_in, psum_valid, out_ready, ovf_clr,
        input  out_data, out_valid, out_last, ovf
    );

    modport slave (
        input  psum_in, psum_valid, out_ready, ovf_clr,
        output out_data, out_valid, out_last, ovf
    );
endinterface

// File: rtl/psum_drain.sv
// Realigns skewed per-column partial sums into rows; 1 cycle from last column capture to out_valid.
// Backpressure: row held stable while !out_ready; a full column drops its sample and sets sticky ovf.
module psum_drain #(
    parameter int COLS  = 4,
    parameter int ACC_W = 16,
    parameter int DEPTH = 4,
    parameter int ROWS  = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    psum_drain_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [CW-1:0] FULL     = CW'(DEPTH);
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

    logic [ACC_W-1:0]      mem [DEPTH][COLS];
    logic [CW-1:0]         wr_cnt [COLS];
    logic [CW-1:0]         rd_cnt;
    logic [CW-1:0]         occ [COLS];
    logic [COLS-1:0]       col_avail;
    logic [COLS-1:0]       col_full;
    logic [COLS-1:0]       wr_en;
    logic [COLS-1:0]       drop;
    logic [RW-1:0]         row_idx;
    logic [AW-1:0]         rd_slot;
    logic [COLS*ACC_W-1:0] row_dat;
    logic                  row_vld;
    logic                  pop;
    logic                  ovf_q;

    // Occupancy uses one extra counter bit so full and empty stay distinct across the wrap.
    always_comb begin
        for (int c = 0; c < COLS; c++) begin
            occ[c]       = wr_cnt[c] - rd_cnt;
            col_avail[c] = (occ[c] != '0);
            col_full[c]  = (occ[c] == FULL);
        end
    end

    assign row_vld = &col_avail;
    assign pop     = row_vld & bus.out_ready;

    // A full column may still accept when the head row leaves in the same cycle.
    always_comb begin
        for (int c = 0; c < COLS; c++) begin
            wr_en[c] = bus.psum_valid[c] & (~col_full[c] | pop);
            drop[c]  = bus.psum_valid[c] & col_full[c] & ~pop;
        end
    end

    assign rd_slot = rd_cnt[AW-1:0];

    always_comb begin
        row_dat = '0;
        for (int c = 0; c < COLS; c++) begin
            row_dat[c*ACC_W +: ACC_W] = mem[rd_slot][c];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < DEPTH; d++) begin
                for (int c = 0; c < COLS; c++) begin
                    mem[d][c] <= '0;
                end
            end
        end else begin
            for (int c = 0; c < COLS; c++) begin
                if (wr_en[c]) begin
                    mem[wr_cnt[c][AW-1:0]][c] <= bus.psum_in[c*ACC_W +: ACC_W];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < COLS; c++) begin
                wr_cnt[c] <= '0;
            end
            rd_cnt  <= '0;
            row_idx <= '0;
            ovf_q   <= 1'b0;
        end else begin
            for (int c = 0; c < COLS; c++) begin
                if (wr_en[c]) begin
                    wr_cnt[c] <= wr_cnt[c] + CW'(1);
                end
            end
            if (pop) begin
                rd_cnt  <= rd_cnt + CW'(1);
                row_idx <= (row_idx == LAST_ROW) ? '0 : row_idx + RW'(1);
            end
            // A drop in the same cycle as a clear keeps the flag set.
            if (|drop) begin
                ovf_q <= 1'b1;
            end else if (bus.ovf_clr) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign bus.out_data  = row_dat;
    assign bus.out_valid = row_vld;
    assign bus.out_last  = row_vld & (row_idx == LAST_ROW);
    assign bus.ovf       = ovf_q;

    hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (row_vld && !bus.out_ready) |=> $stable(bus.out_data));

endmodule

// File: tb/tb_psum_drain.sv
// Scoreboarded bench for psum_drain: directed tiles on a DEPTH=4 and a DEPTH=2 instance.
// Stimulus pushes expected rows (data, last, cycle); per-instance monitors pop on each accepted row.
module tb_psum_drain;

    typedef struct {
        logic [63:0] dat;
        logic        last;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   t0;
    int   n_cmp;
    int   n_bad;
    exp_t qa[$];
    exp_t qb[$];

    psum_drain_if #(.COLS(4), .ACC_W(16)) bus_a ();
    psum_drain_if #(.COLS(4), .ACC_W(16)) bus_b ();

    psum_drain #(.COLS(4), .ACC_W(16), .DEPTH(4), .ROWS(4)) u_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    psum_drain #(.COLS(4), .ACC_W(16), .DEPTH(2), .ROWS(4)) u_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @rel %0d: got %h, expected %h", name, cyc - t0, act, exp);
        end
    endtask

    function automatic logic [63:0] mkrow(input logic [15:0] v0, input logic [15:0] v1,
                                          input logic [15:0] v2, input logic [15:0] v3);
        return {v3, v2, v1, v0};
    endfunction

    function automatic exp_t mkexp(input logic [63:0] d, input logic l, input int c);
        exp_t e;
        e.dat  = d;
        e.last = l;
        e.cyc  = c;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus_a.psum_in = '0; bus_a.psum_valid = '0; bus_a.out_ready = 1'b0; bus_a.ovf_clr = 1'b0;
        bus_b.psum_in = '0; bus_b.psum_valid = '0; bus_b.out_ready = 1'b0; bus_b.ovf_clr = 1'b0;
    endtask

    task automatic set_a(input int c, input logic [15:0] v);
        bus_a.psum_valid[c]      = 1'b1;
        bus_a.psum_in[c*16 +: 16] = v;
    endtask

    task automatic set_b(input int c, input logic [15:0] v);
        bus_b.psum_valid[c]      = 1'b1;
        bus_b.psum_in[c*16 +: 16] = v;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        t0 = cyc;
    endtask

    // Skewed tile on instance A: column c carries (c<<8)|r in cycles 10+c .. 13+c.
    task automatic run_skew(input int n_cycles, input int ready_from);
        for (int k = 0; k < n_cycles; k++) begin
            bus_a.psum_valid = '0;
            bus_a.psum_in    = '0;
            bus_a.out_ready  = (k >= ready_from);
            for (int c = 0; c < 4; c++) begin
                if (k >= 10 + c && k < 14 + c) begin
                    set_a(c, 16'((c << 8) | (k - 10 - c)));
                end
            end
            if (ready_from > 0) begin
                if (k == 13) check("bp_valid_before", 64'(bus_a.out_valid), 64'd0);
                if (k >= 14 && k < ready_from) begin
                    check("bp_valid_hold", 64'(bus_a.out_valid), 64'd1);
                    check("bp_data_hold", bus_a.out_data,
                          mkrow(16'h0000, 16'h0100, 16'h0200, 16'h0300));
                end
            end
            step();
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus_a.out_valid && bus_a.out_ready) begin
            if (qa.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL a_extra_row @rel %0d: got row %h, expected none", cyc - t0, bus_a.out_data);
            end else begin
                exp_t e;
                e = qa.pop_front();
                check("a_row", bus_a.out_data, e.dat);
                check("a_last", 64'(bus_a.out_last), 64'(e.last));
                check("a_cycle", 64'(cyc - t0), 64'(e.cyc));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && bus_b.out_valid && bus_b.out_ready) begin
            if (qb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL b_extra_row @rel %0d: got row %h, expected none", cyc - t0, bus_b.out_data);
            end else begin
                exp_t e;
                e = qb.pop_front();
                check("b_row", bus_b.out_data, e.dat);
                check("b_last", 64'(bus_b.out_last), 64'(e.last));
                check("b_cycle", 64'(cyc - t0), 64'(e.cyc));
            end
        end
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        t0    = 0;
        do_reset();

        check("rst_valid", 64'(bus_a.out_valid), 64'd0);
        check("rst_last", 64'(bus_a.out_last), 64'd0);
        check("rst_ovf", 64'(bus_a.ovf), 64'd0);
        check("rst_b_valid", 64'(bus_b.out_valid), 64'd0);

        // Skewed tile, no backpressure: rows at 14..17.
        for (int r = 0; r < 4; r++) begin
            qa.push_back(mkexp(mkrow(16'(r), 16'(16'h0100 + r), 16'(16'h0200 + r), 16'(16'h0300 + r)),
                               (r == 3), 14 + r));
        end
        run_skew(22, 0);
        check("skew_left", 64'(qa.size()), 64'd0);
        check("skew_ovf", 64'(bus_a.ovf), 64'd0);

        // Backpressure until cycle 20: rows drain at 20..23.
        do_reset();
        for (int r = 0; r < 4; r++) begin
            qa.push_back(mkexp(mkrow(16'(r), 16'(16'h0100 + r), 16'(16'h0200 + r), 16'(16'h0300 + r)),
                               (r == 3), 20 + r));
        end
        run_skew(26, 20);
        check("bp_left", 64'(qa.size()), 64'd0);
        check("bp_ovf", 64'(bus_a.ovf), 64'd0);

        // Overflow on DEPTH=2: third column-0 sample is dropped.
        do_reset();
        qb.push_back(mkexp(mkrow(16'h0001, 16'h0101, 16'h0201, 16'h0301), 1'b0, 5));
        qb.push_back(mkexp(mkrow(16'h0002, 16'h0102, 16'h0202, 16'h0302), 1'b0, 6));
        for (int k = 0; k < 10; k++) begin
            bus_b.psum_valid = '0;
            bus_b.psum_in    = '0;
            bus_b.out_ready  = (k >= 5);
            bus_b.ovf_clr    = (k == 8);
            if (k < 2) begin
                for (int c = 0; c < 4; c++) set_b(c, 16'((c << 8) | (k + 1)));
            end
            if (k == 2) begin
                set_b(0, 16'h0003);
                check("ovf_before_drop", 64'(bus_b.ovf), 64'd0);
            end
            if (k == 3) check("ovf_set", 64'(bus_b.ovf), 64'd1);
            if (k == 7) check("ovf_drained_valid", 64'(bus_b.out_valid), 64'd0);
            if (k == 8) check("ovf_sticky", 64'(bus_b.ovf), 64'd1);
            if (k == 9) check("ovf_cleared", 64'(bus_b.ovf), 64'd0);
            step();
        end
        check("ovf_left", 64'(qb.size()), 64'd0);

        // Full with simultaneous pop and push on DEPTH=2.
        do_reset();
        qb.push_back(mkexp(mkrow(16'h0010, 16'h0011, 16'h0012, 16'h0013), 1'b0, 3));
        qb.push_back(mkexp(mkrow(16'h0020, 16'h0021, 16'h0022, 16'h0023), 1'b0, 6));
        qb.push_back(mkexp(mkrow(16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF), 1'b0, 7));
        for (int k = 0; k < 9; k++) begin
            bus_b.psum_valid = '0;
            bus_b.psum_in    = '0;
            bus_b.out_ready  = (k == 3) || (k >= 6);
            if (k < 2) begin
                for (int c = 0; c < 4; c++) set_b(c, 16'(16'h0010 * (k + 1) + c));
            end
            if (k == 3) begin
                for (int c = 0; c < 4; c++) set_b(c, 16'hBEEF);
            end
            if (k == 4) begin
                check("full_pp_no_drop", 64'(bus_b.ovf), 64'd0);
                for (int c = 0; c < 4; c++) set_b(c, 16'h3333);
            end
            if (k == 5) check("full_still_full", 64'(bus_b.ovf), 64'd1);
            if (k == 8) check("full_drained_valid", 64'(bus_b.out_valid), 64'd0);
            step();
        end
        check("full_left", 64'(qb.size()), 64'd0);

        // Reset mid-tile on A after two rows are captured.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            bus_a.psum_valid = '0;
            bus_a.psum_in    = '0;
            if (k < 2) begin
                for (int c = 0; c < 4; c++) set_a(c, 16'(16'hA000 + k * 16 + c));
            end
            step();
        end
        check("mid_valid_pre", 64'(bus_a.out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_async_valid", 64'(bus_a.out_valid), 64'd0);
        check("mid_async_last", 64'(bus_a.out_last), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        t0 = cyc;
        for (int r = 0; r < 4; r++) begin
            qa.push_back(mkexp(mkrow(16'(16'h5000 + r * 16), 16'(16'h5001 + r * 16),
                                     16'(16'h5002 + r * 16), 16'(16'h5003 + r * 16)), (r == 3), r + 1));
        end
        for (int k = 0; k < 8; k++) begin
            bus_a.psum_valid = '0;
            bus_a.psum_in    = '0;
            bus_a.out_ready  = 1'b1;
            if (k < 4) begin
                for (int c = 0; c < 4; c++) set_a(c, 16'(16'h5000 + k * 16 + c));
            end
            step();
        end
        check("mid_left", 64'(qa.size()), 64'd0);

        // Twenty back-to-back rows across several counter wraps.
        do_reset();
        for (int r = 0; r < 20; r++) begin
            qa.push_back(mkexp(mkrow(16'(16'h1000 + r * 16), 16'(16'h1001 + r * 16),
                                     16'(16'h1002 + r * 16), 16'(16'h1003 + r * 16)), (r % 4 == 3), r + 1));
        end
        for (int k = 0; k < 23; k++) begin
            bus_a.psum_valid = '0;
            bus_a.psum_in    = '0;
            bus_a.out_ready  = 1'b1;
            if (k < 20) begin
                for (int c = 0; c < 4; c++) set_a(c, 16'(16'h1000 + k * 16 + c));
            end
            step();
        end
        check("wrap_left", 64'(qa.size()), 64'd0);
        check("wrap_ovf", 64'(bus_a.ovf), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
